// File: rtl/simulador_planta_vinho_pkg.sv
// Purpose: shared types and defaults for the wine bottling line plant emulator.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package simulador_planta_vinho_pkg;

  // Position of the single bottle travelling through the line.
  typedef enum logic [2:0] {
    INICIO     = 3'd0,
    ENCHIMENTO = 3'd1,
    CQ         = 3'd2,
    FINAL      = 3'd3,
    DESCARTE   = 3'd4
  } estado_t;

  // Default plant timing.
  localparam int TICKS_SEGMENTO_PAD = 4;
  localparam int TICKS_ENCHER_PAD   = 3;
  localparam int TICKS_RETIRADA_PAD = 2;
  localparam int REPROVA_N_PAD      = 3;

  // Width of the delivered/discarded bottle counters and the bottle index.
  localparam int LARGURA_CONTADOR = 8;

  // Bits needed to hold values 0..n; never less than one bit.
  function automatic int largura_cnt(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/simulador_planta_vinho_contador.sv
// Purpose: small counter with enable/clear; wraps at LIMITE-1 or saturates at LIMITE.
// Latency: done is a flop, true in the same cycle the count reaches its target.
// Backpressure: none; en is sampled every cycle, clr wins over en.
module contador_modulo
  import simulador_planta_vinho_pkg::*;
#(
  parameter int LIMITE = 4,
  parameter bit SATURA = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic done
);

  localparam int W = largura_cnt(LIMITE);
  // Terminal-count mode flags LIMITE-1 (and wraps there); saturating mode flags LIMITE.
  localparam logic [W-1:0] ALVO = SATURA ? W'(LIMITE) : W'(LIMITE - 1);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_prox;

  // Next count: clear first, then advance (wrap or hold at the target).
  always_comb begin
    cnt_prox = cnt;
    if (clr) begin
      cnt_prox = '0;
    end else if (en) begin
      if (cnt == ALVO) begin
        cnt_prox = SATURA ? cnt : '0;
      end else begin
        cnt_prox = cnt + 1'b1;
      end
    end
  end

  // Count and done are both registered so done can drive an output directly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      done <= (ALVO == '0);
    end else begin
      cnt  <= cnt_prox;
      done <= (cnt_prox == ALVO);
    end
  end

endmodule

// File: rtl/simulador_planta_vinho.sv
// Purpose: plant emulator; turns controller actuator commands into station/level/QC sensors.
// Latency: every output is a flop; sensors change one cycle after the qualifying command.
// Backpressure: none; commands are sampled every cycle and illegal ones raise erro_planta.
module simulador_planta_vinho
  import simulador_planta_vinho_pkg::*;
#(
  parameter int TICKS_SEGMENTO = TICKS_SEGMENTO_PAD,
  parameter int TICKS_ENCHER   = TICKS_ENCHER_PAD,
  parameter int TICKS_RETIRADA = TICKS_RETIRADA_PAD,
  parameter int REPROVA_N      = REPROVA_N_PAD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       motor_ativo,
  input  logic       valvula_ativa,
  input  logic       vedacao_ativa,
  input  logic       descarte_ativo,
  output logic       sensor_posicao_enchimento,
  output logic       sensor_nivel,
  output logic       sensor_posicao_cq,
  output logic       resultado_cq,
  output logic       sensor_final,
  output logic       erro_planta,
  output logic [7:0] garrafas_entregues,
  output logic [7:0] garrafas_descartadas
);

  estado_t                     estado;
  logic                        vedada;
  logic                        aprovada;
  logic [LARGURA_CONTADOR-1:0] indice_garrafa;

  logic cheia;
  logic pos_done;
  logic ret_done;
  logic falha_injetada;
  logic falha_comando;

  logic pos_en, pos_clr;
  logic nivel_en, nivel_clr;
  logic ret_en;
  logic saida_enchimento;
  logic descarte_cq;
  logic remocao;

  // A bottle is moved by the motor everywhere except at the end positions,
  // and a discard command at QC freezes conveyor travel for that cycle.
  assign descarte_cq      = (estado == CQ) && descarte_ativo;
  assign pos_en           = motor_ativo &&
                            ((estado == INICIO) || (estado == ENCHIMENTO) ||
                             ((estado == CQ) && !descarte_ativo));
  assign saida_enchimento = (estado == ENCHIMENTO) && motor_ativo && pos_done;
  assign ret_en           = (estado == FINAL) || (estado == DESCARTE);
  assign remocao          = ret_en && ret_done;
  assign pos_clr          = remocao || descarte_cq;

  // Level only builds at the filling station; it is dropped when the bottle
  // leaves so sensor_nivel never reports a bottle that is no longer there.
  assign nivel_en  = (estado == ENCHIMENTO) && valvula_ativa;
  assign nivel_clr = saida_enchimento || remocao;

  assign sensor_nivel = cheia;
  assign resultado_cq = aprovada;

  contador_modulo #(
    .LIMITE (TICKS_SEGMENTO),
    .SATURA (1'b0)
  ) u_pos_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (pos_en),
    .clr   (pos_clr),
    .done  (pos_done)
  );

  contador_modulo #(
    .LIMITE (TICKS_ENCHER),
    .SATURA (1'b1)
  ) u_nivel_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (nivel_en),
    .clr   (nivel_clr),
    .done  (cheia)
  );

  contador_modulo #(
    .LIMITE (TICKS_RETIRADA),
    .SATURA (1'b0)
  ) u_ret_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (ret_en),
    .clr   (1'b0),
    .done  (ret_done)
  );

  // Every REPROVA_N-th bottle is forced to fail QC; REPROVA_N = 0 turns this off.
  if (REPROVA_N > 0) begin : g_injecao
    assign falha_injetada = ((int'(indice_garrafa) % REPROVA_N) == (REPROVA_N - 1));
  end else begin : g_sem_injecao
    assign falha_injetada = 1'b0;
  end

  // Commands that a real plant could not honour (or that would spill wine).
  assign falha_comando = (valvula_ativa  && (estado != ENCHIMENTO)) ||
                         (valvula_ativa  && cheia) ||
                         (vedacao_ativa  && (estado != ENCHIMENTO)) ||
                         (descarte_ativo && (estado != CQ));

  // Bottle position FSM with registered station sensors, QC latch and tallies.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado                    <= INICIO;
      vedada                    <= 1'b0;
      aprovada                  <= 1'b0;
      indice_garrafa            <= '0;
      sensor_posicao_enchimento <= 1'b0;
      sensor_posicao_cq         <= 1'b0;
      sensor_final              <= 1'b0;
      erro_planta               <= 1'b0;
      garrafas_entregues        <= '0;
      garrafas_descartadas      <= '0;
    end else begin
      if (falha_comando) begin
        erro_planta <= 1'b1;
      end

      case (estado)
        INICIO: begin
          if (motor_ativo && pos_done) begin
            estado                    <= ENCHIMENTO;
            sensor_posicao_enchimento <= 1'b1;
          end
        end

        ENCHIMENTO: begin
          if (vedacao_ativa && cheia) begin
            vedada <= 1'b1;
          end
          if (saida_enchimento) begin
            estado                    <= CQ;
            sensor_posicao_enchimento <= 1'b0;
            sensor_posicao_cq         <= 1'b1;
            // A seal applied in the leaving cycle still counts.
            aprovada <= cheia && (vedada || vedacao_ativa) && !falha_injetada;
          end
        end

        CQ: begin
          if (descarte_ativo) begin
            estado            <= DESCARTE;
            sensor_posicao_cq <= 1'b0;
            aprovada          <= 1'b0;
          end else if (motor_ativo && pos_done) begin
            estado            <= FINAL;
            sensor_posicao_cq <= 1'b0;
            aprovada          <= 1'b0;
            sensor_final      <= 1'b1;
          end
        end

        FINAL: begin
          if (ret_done) begin
            estado             <= INICIO;
            sensor_final       <= 1'b0;
            garrafas_entregues <= garrafas_entregues + 1'b1;
            indice_garrafa     <= indice_garrafa + 1'b1;
            vedada             <= 1'b0;
          end
        end

        DESCARTE: begin
          if (ret_done) begin
            estado               <= INICIO;
            garrafas_descartadas <= garrafas_descartadas + 1'b1;
            indice_garrafa       <= indice_garrafa + 1'b1;
            vedada               <= 1'b0;
          end
        end

        default: begin
          estado <= INICIO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simulador_planta_vinho.sv
// Purpose: directed self-checking bench for the plant emulator at default timing (4/3/2/3).
// Latency: inputs change 1 time unit after a rising edge; outputs are read at the same point.
// Backpressure: n/a; every scenario runs a fixed number of cycles.
module tb_simulador_planta_vinho;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       motor_ativo = 1'b0;
  logic       valvula_ativa = 1'b0;
  logic       vedacao_ativa = 1'b0;
  logic       descarte_ativo = 1'b0;
  logic       sensor_posicao_enchimento;
  logic       sensor_nivel;
  logic       sensor_posicao_cq;
  logic       resultado_cq;
  logic       sensor_final;
  logic       erro_planta;
  logic [7:0] garrafas_entregues;
  logic [7:0] garrafas_descartadas;

  int total = 0;
  int bad   = 0;

  simulador_planta_vinho dut (
    .clk                       (clk),
    .reset                     (reset),
    .motor_ativo               (motor_ativo),
    .valvula_ativa             (valvula_ativa),
    .vedacao_ativa             (vedacao_ativa),
    .descarte_ativo            (descarte_ativo),
    .sensor_posicao_enchimento (sensor_posicao_enchimento),
    .sensor_nivel              (sensor_nivel),
    .sensor_posicao_cq         (sensor_posicao_cq),
    .resultado_cq              (resultado_cq),
    .sensor_final              (sensor_final),
    .erro_planta               (erro_planta),
    .garrafas_entregues        (garrafas_entregues),
    .garrafas_descartadas      (garrafas_descartadas)
  );

  always #5 clk = ~clk;

  // One clock cycle with the given commands; returns 1 unit after the edge.
  task automatic passo(input logic m, input logic v, input logic s, input logic d);
    motor_ativo    = m;
    valvula_ativa  = v;
    vedacao_ativa  = s;
    descarte_ativo = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pulso_reset();
    reset = 1'b0;
    passo(0, 0, 0, 0);
    reset = 1'b1;
  endtask

  // Walk one bottle from INICIO to the QC station, sealing it or not.
  task automatic levar_ate_cq(input logic selar);
    repeat (4) passo(1, 0, 0, 0);
    repeat (3) passo(0, 1, 0, 0);
    if (selar) passo(0, 0, 1, 0);
    repeat (4) passo(1, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) passo(0, 0, 0, 0);
    total++;
    if ({sensor_posicao_enchimento, sensor_nivel, sensor_posicao_cq, resultado_cq,
         sensor_final, erro_planta, garrafas_entregues, garrafas_descartadas} !== 22'd0) begin
      $display("FAIL reset_outputs got=%h exp=0",
               {sensor_posicao_enchimento, sensor_nivel, sensor_posicao_cq, resultado_cq,
                sensor_final, erro_planta, garrafas_entregues, garrafas_descartadas});
      bad++;
    end
    reset = 1'b1;
    passo(0, 0, 0, 0);
    total++;
    if ({sensor_posicao_enchimento, sensor_posicao_cq, sensor_final, erro_planta} !== 4'b0000) begin
      $display("FAIL idle_after_reset got=%b exp=0000",
               {sensor_posicao_enchimento, sensor_posicao_cq, sensor_final, erro_planta});
      bad++;
    end
  endtask

  task automatic test_nominal();
    repeat (3) passo(1, 0, 0, 0);
    total++;
    if (sensor_posicao_enchimento !== 1'b0) begin
      $display("FAIL nom_ench_early got=%b exp=0", sensor_posicao_enchimento); bad++;
    end
    passo(1, 0, 0, 0);
    total++;
    if (sensor_posicao_enchimento !== 1'b1) begin
      $display("FAIL nom_ench got=%b exp=1", sensor_posicao_enchimento); bad++;
    end
    repeat (2) passo(0, 1, 0, 0);
    total++;
    if (sensor_nivel !== 1'b0) begin
      $display("FAIL nom_nivel_early got=%b exp=0", sensor_nivel); bad++;
    end
    passo(0, 1, 0, 0);
    total++;
    if (sensor_nivel !== 1'b1) begin
      $display("FAIL nom_nivel got=%b exp=1", sensor_nivel); bad++;
    end
    passo(0, 0, 1, 0);
    repeat (3) passo(1, 0, 0, 0);
    total++;
    if (sensor_posicao_cq !== 1'b0) begin
      $display("FAIL nom_cq_early got=%b exp=0", sensor_posicao_cq); bad++;
    end
    passo(1, 0, 0, 0);
    total++;
    if ({sensor_posicao_enchimento, sensor_nivel, sensor_posicao_cq, resultado_cq} !== 4'b0011) begin
      $display("FAIL nom_cq got=%b exp=0011",
               {sensor_posicao_enchimento, sensor_nivel, sensor_posicao_cq, resultado_cq});
      bad++;
    end
    repeat (4) passo(1, 0, 0, 0);
    total++;
    if ({sensor_posicao_cq, resultado_cq, sensor_final} !== 3'b001) begin
      $display("FAIL nom_final got=%b exp=001", {sensor_posicao_cq, resultado_cq, sensor_final}); bad++;
    end
    passo(0, 0, 0, 0);
    total++;
    if ({sensor_final, garrafas_entregues} !== {1'b1, 8'd0}) begin
      $display("FAIL nom_final_hold got=%b/%0d exp=1/0", sensor_final, garrafas_entregues); bad++;
    end
    passo(0, 0, 0, 0);
    total++;
    if ({sensor_final, garrafas_entregues, erro_planta} !== {1'b0, 8'd1, 1'b0}) begin
      $display("FAIL nom_entregue got final=%b ent=%0d err=%b exp 0/1/0",
               sensor_final, garrafas_entregues, erro_planta);
      bad++;
    end
  endtask

  task automatic test_injecao();
    levar_ate_cq(1'b1);
    total++;
    if ({sensor_posicao_cq, resultado_cq} !== 2'b11) begin
      $display("FAIL inj_bottle1_ok got=%b exp=11", {sensor_posicao_cq, resultado_cq}); bad++;
    end
    repeat (4) passo(1, 0, 0, 0);
    repeat (2) passo(0, 0, 0, 0);
    levar_ate_cq(1'b1);
    total++;
    if ({sensor_posicao_cq, resultado_cq, garrafas_entregues} !== {2'b10, 8'd2}) begin
      $display("FAIL inj_bottle2_reject got=%b/%0d exp=10/2",
               {sensor_posicao_cq, resultado_cq}, garrafas_entregues);
      bad++;
    end
    passo(0, 0, 0, 1);
    total++;
    if ({sensor_posicao_cq, resultado_cq, sensor_final} !== 3'b000) begin
      $display("FAIL inj_discard_leave got=%b exp=000",
               {sensor_posicao_cq, resultado_cq, sensor_final});
      bad++;
    end
    passo(0, 0, 0, 0);
    total++;
    if (garrafas_descartadas !== 8'd0) begin
      $display("FAIL inj_discard_early got=%0d exp=0", garrafas_descartadas); bad++;
    end
    passo(0, 0, 0, 0);
    total++;
    if ({garrafas_descartadas, garrafas_entregues, erro_planta} !== {8'd1, 8'd2, 1'b0}) begin
      $display("FAIL inj_counts got desc=%0d ent=%0d err=%b exp 1/2/0",
               garrafas_descartadas, garrafas_entregues, erro_planta);
      bad++;
    end
  endtask

  task automatic test_sem_vedacao();
    levar_ate_cq(1'b0);
    total++;
    if ({sensor_posicao_cq, resultado_cq} !== 2'b10) begin
      $display("FAIL unsealed_qc got=%b exp=10", {sensor_posicao_cq, resultado_cq}); bad++;
    end
    passo(0, 0, 0, 1);
    repeat (2) passo(0, 0, 0, 0);
    total++;
    if (garrafas_descartadas !== 8'd2) begin
      $display("FAIL unsealed_discard got=%0d exp=2", garrafas_descartadas); bad++;
    end
  endtask

  task automatic test_falhas();
    total++;
    if (erro_planta !== 1'b0) begin
      $display("FAIL fault_clean got=%b exp=0", erro_planta); bad++;
    end
    passo(0, 1, 0, 0);
    total++;
    if (erro_planta !== 1'b1) begin
      $display("FAIL fault_valve_inicio got=%b exp=1", erro_planta); bad++;
    end
    repeat (3) passo(0, 0, 0, 0);
    total++;
    if (erro_planta !== 1'b1) begin
      $display("FAIL fault_sticky got=%b exp=1", erro_planta); bad++;
    end
    pulso_reset();
    total++;
    if (erro_planta !== 1'b0) begin
      $display("FAIL fault_reset_clear got=%b exp=0", erro_planta); bad++;
    end
    repeat (4) passo(1, 0, 0, 0);
    repeat (3) passo(0, 1, 0, 0);
    total++;
    if ({sensor_nivel, erro_planta} !== 2'b10) begin
      $display("FAIL overflow_before got=%b exp=10", {sensor_nivel, erro_planta}); bad++;
    end
    passo(0, 1, 0, 0);
    total++;
    if (erro_planta !== 1'b1) begin
      $display("FAIL overflow got=%b exp=1", erro_planta); bad++;
    end
  endtask

  task automatic test_motor_interrompido();
    pulso_reset();
    repeat (2) passo(1, 0, 0, 0);
    repeat (5) passo(0, 0, 0, 0);
    passo(1, 0, 0, 0);
    total++;
    if (sensor_posicao_enchimento !== 1'b0) begin
      $display("FAIL interrupt_3rd got=%b exp=0", sensor_posicao_enchimento); bad++;
    end
    passo(1, 0, 0, 0);
    total++;
    if (sensor_posicao_enchimento !== 1'b1) begin
      $display("FAIL interrupt_4th got=%b exp=1", sensor_posicao_enchimento); bad++;
    end
  endtask

  task automatic test_reset_enchimento();
    pulso_reset();
    repeat (4) passo(1, 0, 0, 0);
    repeat (2) passo(0, 1, 0, 0);
    reset = 1'b0;
    passo(0, 0, 0, 0);
    total++;
    if ({sensor_posicao_enchimento, sensor_nivel, sensor_posicao_cq, resultado_cq,
         sensor_final, erro_planta, garrafas_entregues, garrafas_descartadas} !== 22'd0) begin
      $display("FAIL midfill_reset got=%h exp=0",
               {sensor_posicao_enchimento, sensor_nivel, sensor_posicao_cq, resultado_cq,
                sensor_final, erro_planta, garrafas_entregues, garrafas_descartadas});
      bad++;
    end
    reset = 1'b1;
    repeat (3) passo(1, 0, 0, 0);
    total++;
    if (sensor_posicao_enchimento !== 1'b0) begin
      $display("FAIL midfill_motor3 got=%b exp=0", sensor_posicao_enchimento); bad++;
    end
    passo(1, 0, 0, 0);
    total++;
    if ({sensor_posicao_enchimento, sensor_nivel, garrafas_entregues, garrafas_descartadas}
        !== {2'b10, 16'd0}) begin
      $display("FAIL midfill_motor4 got ench=%b nivel=%b ent=%0d desc=%0d exp 1/0/0/0",
               sensor_posicao_enchimento, sensor_nivel, garrafas_entregues, garrafas_descartadas);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_injecao();
    test_sem_vedacao();
    test_falhas();
    test_motor_interrompido();
    test_reset_enchimento();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simulador_planta_vinho.md
# simulador_planta_vinho

Plant emulator for the wine bottling line: the physical-side counterpart of the sensor and actuator interface that the line controller drives. It consumes the controller's actuator outputs (conveyor motor, filling valve, sealer, discard) and generates the station sensors, fill-level sensor and QC result that the switches otherwise supply. It lets the full controller run closed-loop in simulation and on the board, with deterministic bottle timing and injected QC failures.

## Interface
Parameters:
- TICKS_SEGMENTO, 4: motor-on cycles needed to move a bottle between adjacent stations.
- TICKS_ENCHER, 3: valve-on cycles needed to reach full level.
- TICKS_RETIRADA, 2: cycles a bottle stays at the final or discard position before removal.
- REPROVA_N, 3: every REPROVA_N-th bottle (index mod N = N-1) fails QC; 0 disables injection.

Ports:
- clk  in  1  system clock (CLOCK_50 at top)
- reset  in  1  synchronous, active-low reset (connect KEY[1] directly)
- motor_ativo  in  1  conveyor motor command
- valvula_ativa  in  1  filling valve command
- vedacao_ativa  in  1  sealer command
- descarte_ativo  in  1  discard actuator command
- sensor_posicao_enchimento  out  1  bottle at filling station
- sensor_nivel  out  1  bottle full
- sensor_posicao_cq  out  1  bottle at QC station
- resultado_cq  out  1  1 = approved; valid while sensor_posicao_cq = 1
- sensor_final  out  1  bottle at end of line
- erro_planta  out  1  sticky fault flag
- garrafas_entregues  out  8  bottles removed at final (wraps)
- garrafas_descartadas  out  8  bottles removed at discard (wraps)

## Operation
- States: INICIO, ENCHIMENTO, CQ, FINAL, DESCARTE. Per-bottle flags: cheia, vedada. Internal 8-bit indice_garrafa.
- INICIO: each cycle with motor_ativo=1, pos_cnt increments; when motor_ativo=1 and pos_cnt = TICKS_SEGMENTO-1, go to ENCHIMENTO and clear pos_cnt. With motor_ativo=0, pos_cnt holds and does not decay.
- ENCHIMENTO: valvula_ativa increments nivel_cnt, which saturates at TICKS_ENCHER. cheia = (nivel_cnt = TICKS_ENCHER). Any cycle with vedacao_ativa=1 and cheia=1 sets vedada. Motor travel uses the same rule as INICIO and leads to CQ.
- CQ entry: latch aprovada = cheia AND vedada AND NOT injected failure. descarte_ativo=1 leads to DESCARTE, and takes priority over motor in the same cycle. Otherwise motor travel leads to FINAL.
- FINAL and DESCARTE: motor and valve commands are ignored. ret_cnt counts TICKS_RETIRADA cycles. On expiry, the matching counter increments, indice_garrafa increments, the flags and counters clear, and the state returns to INICIO.
- erro_planta is set (sticky until reset) when:
  - valvula_ativa=1 outside ENCHIMENTO;
  - valvula_ativa=1 while cheia=1 (overflow);
  - vedacao_ativa=1 outside ENCHIMENTO;
  - descarte_ativo=1 outside CQ.
- Counter rules: 8-bit wrap 255→0. pos_cnt, nivel_cnt and ret_cnt are sized by clog2 of their parameter.

## Timing
- Reset value: state INICIO, all counters 0, cheia, vedada and aprovada cleared, all outputs 0. Reset mid-operation discards the bottle without counting it.
- All outputs are registered. Sensors reflect the new state in the cycle after the transition edge: 1-cycle latency from the qualifying input to the sensor change.
- sensor_nivel rises in the cycle after the TICKS_ENCHER-th valve-on cycle.
- resultado_cq is 0 whenever sensor_posicao_cq=0.
- sensor_final stays high for exactly TICKS_RETIRADA cycles. garrafas_entregues updates in the same cycle that sensor_final falls.
- Simultaneous motor and valve in ENCHIMENTO: both take effect. The bottle can leave partly filled and then fails QC.

## Structure
- Shared package holds the state encoding enum, default parameter constants and the counter width (8).
- Natural sub-module: contador_modulo (parameterized saturating/terminal-count counter with enable, clear and done). Instantiate it for pos_cnt, nivel_cnt and ret_cnt.

## Test plan
All scenarios use the defaults (4/3/2/3).
- Nominal bottle: motor 4 cycles → sensor_posicao_enchimento=1; valve 3 cycles → sensor_nivel=1; one vedacao pulse; motor 4 → sensor_posicao_cq=1 with resultado_cq=1; motor 4 → sensor_final high 2 cycles; garrafas_entregues=1, erro_planta=0.
- Injection: run 3 nominal bottles → third shows resultado_cq=0; descarte pulse → DESCARTE; after 2 cycles garrafas_descartadas=1, entregues=2.
- Unsealed: fill but skip vedacao → resultado_cq=0 at CQ.
- Faults: valve pulse in INICIO → erro_planta=1 next cycle and stays 1; separately, 4th valve cycle at full level → erro_planta=1.
- Interrupted motor: motor 2 cycles, idle 5, motor 2 → enchimento sensor rises only after the 4th motor-on cycle.
- Reset mid-fill (reset=0 for 1 cycle at nivel_cnt=2) → all outputs 0, next motor sequence needs 4 cycles, counters stay 0.
